// File: rtl/ecc65_pkg.sv
// Shared SECDED (Hsiao-style) definitions for the 65-bit ECC encoder and decoder.
// Column table and encode function live here so both sides stay identical.
package ecc65_pkg;

  localparam int ECC65_DATA_WIDTH   = 65;
  localparam int ECC65_PARITY_WIDTH = 8;

  typedef struct packed {
    logic [ECC65_DATA_WIDTH-1:0]   data;
    logic [ECC65_PARITY_WIDTH-1:0] parity;
  } ecc65_word_t;

  // Column idx: idx-th non-power-of-two from 3 upward, bit7 makes the column odd weight.
  function automatic logic [ECC65_PARITY_WIDTH-1:0] ecc65_col(input int idx);
    logic [ECC65_PARITY_WIDTH-1:0] col;
    int n;
    col = '0;
    n   = 0;
    for (int v = 3; v <= 72; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (n == idx) begin
          col[6:0] = v[6:0];
        end
        n++;
      end
    end
    col[7] = ~^col[6:0];
    return col;
  endfunction

  function automatic logic [ECC65_PARITY_WIDTH-1:0] ecc65_encode(
    input logic [ECC65_DATA_WIDTH-1:0] data
  );
    logic [ECC65_PARITY_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < ECC65_DATA_WIDTH; i++) begin
      if (data[i]) begin
        p = p ^ ecc65_col(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc_65_skid.sv
// Output register plus one-entry skid buffer; full throughput with in_ready
// depending only on local state, never on out_ready.
module ecc_65_skid #(
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_payload_reg, out_payload_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [WIDTH-1:0] skid_payload_reg, skid_payload_next;
  logic             in_fire;
  logic             out_fire;

  assign in_ready    = ~skid_valid_reg & ~rst;
  assign out_valid   = out_valid_reg;
  assign out_payload = out_payload_reg;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid_reg & out_ready;

  always_comb begin
    out_valid_next    = out_valid_reg;
    out_payload_next  = out_payload_reg;
    skid_valid_next   = skid_valid_reg;
    skid_payload_next = skid_payload_reg;
    if (!out_valid_reg || out_fire) begin
      // Skid holds the older word, so it always drains before new input.
      if (skid_valid_reg) begin
        out_valid_next   = 1'b1;
        out_payload_next = skid_payload_reg;
        skid_valid_next  = 1'b0;
      end else if (in_fire) begin
        out_valid_next   = 1'b1;
        out_payload_next = in_payload;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_next   = 1'b1;
      skid_payload_next = in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_payload_reg  <= '0;
      skid_valid_reg   <= 1'b0;
      skid_payload_reg <= '0;
    end else begin
      out_valid_reg    <= out_valid_next;
      out_payload_reg  <= out_payload_next;
      skid_valid_reg   <= skid_valid_next;
      skid_payload_reg <= skid_payload_next;
    end
  end

endmodule

// File: rtl/ecc_65_enc_pipe.sv
// Pipelined 65-bit SECDED encoder with ready/valid handshakes and a skid buffer.
// Optional error injection ports (inj_sbit/inj_dbit) when ECC_ERR_INJ_EN is defined.
module ecc_65_enc_pipe
  import ecc65_pkg::*;
#(
  parameter int DATA_WIDTH   = 65,
  parameter int PARITY_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_bypass,
`ifdef ECC_ERR_INJ_EN
  input  logic                    inj_sbit,
  input  logic                    inj_dbit,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  output logic [15:0]             enc_cnt
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + PARITY_WIDTH;

  logic [PARITY_WIDTH-1:0]  parity;
  logic [DATA_WIDTH-1:0]    data_mod;
  logic [PAYLOAD_WIDTH-1:0] out_payload;
  logic [15:0]              enc_cnt_reg;

  assign parity = in_bypass ? '0 : ecc65_encode(in_data);

`ifdef ECC_ERR_INJ_EN
  // Errors are applied after encoding so the decoder sees a real corruption.
  always_comb begin
    data_mod = in_data;
    if (inj_dbit) begin
      data_mod[1:0] = in_data[1:0] ^ 2'b11;
    end else if (inj_sbit) begin
      data_mod[0] = ~in_data[0];
    end
  end
`else
  assign data_mod = in_data;
`endif

  ecc_65_skid #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload ({data_mod, parity}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload)
  );

  assign out_data   = out_payload[PAYLOAD_WIDTH-1:PARITY_WIDTH];
  assign out_parity = out_payload[PARITY_WIDTH-1:0];
  assign enc_cnt    = enc_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_cnt_reg <= '0;
    end else if (out_valid && out_ready && enc_cnt_reg != 16'hFFFF) begin
      enc_cnt_reg <= enc_cnt_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_ecc_65_enc_pipe.sv
// Scoreboard bench for ecc_65_enc_pipe: driver pushes expected words, monitor
// pops on every output handshake. Injection cases need ECC_ERR_INJ_EN.
module tb_ecc_65_enc_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bypass = 1'b0;
  logic        out_ready = 1'b1;
  logic [64:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [64:0] out_data;
  logic [7:0]  out_parity;
  logic [15:0] enc_cnt;
`ifdef ECC_ERR_INJ_EN
  logic        inj_sbit = 1'b0;
  logic        inj_dbit = 1'b0;
`endif

  ecc_65_enc_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
`ifdef ECC_ERR_INJ_EN
    .inj_sbit  (inj_sbit),
    .inj_dbit  (inj_dbit),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_parity(out_parity),
    .enc_cnt   (enc_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          exp_cnt = 0;
  logic [72:0] exp_q[$];
  logic [72:0] mon_exp;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, between driver updates and the handshake edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
    end else begin
      check("enc_cnt_track", 73'(enc_cnt), 73'(exp_cnt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got data=%h parity=%h, nothing expected", out_data, out_parity);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("[TB] out data=%h parity=%h expected data=%h parity=%h",
                   out_data, out_parity, mon_exp[72:8], mon_exp[7:0]);
          check("out_word", {out_data, out_parity}, mon_exp);
        end
        exp_cnt++;
      end
    end
  end

  task automatic send(input logic [64:0] d, input logic byp, input logic si, input logic di,
                      input logic [72:0] exp, output int waits);
    logic accepted;
    in_valid  = 1'b1;
    in_data   = d;
    in_bypass = byp;
`ifdef ECC_ERR_INJ_EN
    inj_sbit  = si;
    inj_dbit  = di;
`else
    if (si || di) $display("[TB] injection not built, flags ignored");
`endif
    waits    = 0;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else waits++;
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed %b for data=%h, required 1", in_ready, d);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    $display("[TB] in data=%h bypass=%b sbit=%b dbit=%b waits=%0d", d, byp, si, di, waits);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
`ifdef ECC_ERR_INJ_EN
    inj_sbit  = 1'b0;
    inj_dbit  = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 73'(out_valid), 73'(0));
    check("rst_in_ready", 73'(in_ready), 73'(0));
    check("rst_out_word", {out_data, out_parity}, 73'(0));
    check("rst_enc_cnt", 73'(enc_cnt), 73'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 73'(in_ready), 73'(1));

    // Zero word, latency 1
    send(65'h0, 1'b0, 1'b0, 1'b0, {65'h0, 8'h00}, w);
    check("lat1_out_valid", 73'(out_valid), 73'(1));
    check("lat1_word", {out_data, out_parity}, {65'h0, 8'h00});
    idle();
    @(posedge clk);
    #1;
    check("enc_cnt_one", 73'(enc_cnt), 73'(1));

    // Back-to-back words at full rate
    send(65'h1, 1'b0, 1'b0, 1'b0, {65'h1, 8'h83}, w);
    check("tput_w0", 73'(w), 73'(0));
    send(65'h3, 1'b0, 1'b0, 1'b0, {65'h3, 8'h06}, w);
    check("tput_w1", 73'(w), 73'(0));
    send({1'b1, 64'h0}, 1'b0, 1'b0, 1'b0, {1'b1, 64'h0, 8'hC8}, w);
    check("tput_w2", 73'(w), 73'(0));
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Output stalled three cycles while two words arrive
    out_ready = 1'b0;
    send(65'h5, 1'b0, 1'b0, 1'b0, {65'h5, 8'h05}, w);
    check("stall_w0", 73'(w), 73'(0));
    send(65'h100, 1'b0, 1'b0, 1'b0, {65'h100, 8'h0D}, w);
    check("stall_w1_to_skid", 73'(w), 73'(0));
    check("skid_in_ready_low", 73'(in_ready), 73'(0));
    check("stall_head", {out_data, out_parity}, {65'h5, 8'h05});
    idle();
    @(posedge clk);
    #1;
    check("stall_hold_valid", 73'(out_valid), 73'(1));
    check("stall_hold_word", {out_data, out_parity}, {65'h5, 8'h05});
    check("stall_hold_in_ready", 73'(in_ready), 73'(0));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("skid_drained_in_ready", 73'(in_ready), 73'(1));

    // Bypass forces zero parity
    send(65'h1, 1'b1, 1'b0, 1'b0, {65'h1, 8'h00}, w);
    idle();

`ifdef ECC_ERR_INJ_EN
    send(65'h0, 1'b0, 1'b0, 1'b1, {65'h3, 8'h00}, w);
    send(65'h0, 1'b0, 1'b1, 1'b0, {65'h1, 8'h00}, w);
    send(65'h0, 1'b0, 1'b1, 1'b1, {65'h3, 8'h00}, w);
    send(65'h1, 1'b0, 1'b1, 1'b0, {65'h0, 8'h83}, w);
    idle();
`endif
    repeat (3) @(posedge clk);
    #1;

    // Reset during a stall discards both buffered words
    out_ready = 1'b0;
    send(65'h7, 1'b0, 1'b0, 1'b0, {65'h7, 8'h80}, w);
    send(65'h10, 1'b0, 1'b0, 1'b0, {65'h10, 8'h89}, w);
    idle();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 73'(out_valid), 73'(0));
    check("midrst_enc_cnt", 73'(enc_cnt), 73'(0));
    check("midrst_in_ready", 73'(in_ready), 73'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", 73'(in_ready), 73'(1));
    check("postrst_out_valid", 73'(out_valid), 73'(0));
    send(65'h2, 1'b0, 1'b0, 1'b0, {65'h2, 8'h85}, w);
    idle();

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 73'(exp_q.size()), 73'(0));
    check("final_enc_cnt", 73'(enc_cnt), 73'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
